// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one binary<->gray converter between N_REQ requesters.
// Define GRAY_CONV_FAST_EN to convert the whole word in a single CONV cycle instead of bit-serially.
module gray_conv_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 4,
    parameter int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ-1:0]       req_mode,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WIDTH-1:0]       rsp_data,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   rsp_mode,
    output logic                   busy
);

    localparam logic [ID_W:0] N_SUM = (ID_W+1)'(N_REQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic              mode_q, mode_d;
    logic [WIDTH-1:0]  in_q, in_d;
    logic [WIDTH-1:0]  res_q, res_d;

    logic [N_REQ-1:0]  rot_c;
    logic [ID_W-1:0]   off_c;
    logic [ID_W:0]     sum_c;
    logic [ID_W-1:0]   gnt_id_c;
    logic [N_REQ-1:0]  gnt_oh_c;
    logic [WIDTH-1:0]  gnt_data_c;
    logic              gnt_mode_c;
    logic              gnt_found_c;

    // Rotate so bit 0 is the requester just after the last winner; lowest set bit wins.
    assign rot_c       = N_REQ'({req_valid, req_valid} >> ({1'b0, ptr_q} + (ID_W+1)'(1)));
    assign gnt_found_c = |req_valid;

    always_comb begin
        off_c = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot_c[i]) begin
                off_c = ID_W'(i);
            end
        end
    end

    assign sum_c    = {1'b0, ptr_q} + (ID_W+1)'(1) + {1'b0, off_c};
    assign gnt_id_c = (sum_c >= N_SUM) ? ID_W'(sum_c - N_SUM) : ID_W'(sum_c);

    always_comb begin
        gnt_data_c = '0;
        gnt_mode_c = 1'b0;
        gnt_oh_c   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_id_c == ID_W'(i)) begin
                gnt_data_c  = req_data[i*WIDTH +: WIDTH];
                gnt_mode_c  = req_mode[i];
                gnt_oh_c[i] = 1'b1;
            end
        end
    end

`ifdef GRAY_CONV_FAST_EN
    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b = g;
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction
`else
    localparam int unsigned IDX_W = $clog2(WIDTH);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] in_up_c;
    logic [WIDTH-1:0] res_up_c;
    logic             bit_c;

    // Neighbour above the current bit; the result register is cleared at grant so the MSB sees 0.
    assign in_up_c  = in_q >> 1;
    assign res_up_c = res_q >> 1;
    assign bit_c    = in_q[idx_q] ^ (mode_q ? res_up_c[idx_q] : in_up_c[idx_q]);
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        mode_d  = mode_q;
        in_d    = in_q;
        res_d   = res_q;
`ifndef GRAY_CONV_FAST_EN
        idx_d   = idx_q;
`endif
        case (state_q)
            IDLE: begin
                if (gnt_found_c) begin
                    state_d = CONV;
                    ptr_d   = gnt_id_c;
                    id_d    = gnt_id_c;
                    mode_d  = gnt_mode_c;
                    in_d    = gnt_data_c;
                    res_d   = '0;
`ifndef GRAY_CONV_FAST_EN
                    idx_d   = IDX_W'(WIDTH - 1);
`endif
                end
            end
            CONV: begin
`ifdef GRAY_CONV_FAST_EN
                res_d   = mode_q ? gray2bin(in_q) : (in_q ^ (in_q >> 1));
                state_d = RESP;
`else
                res_d[idx_q] = bit_c;
                if (idx_q == '0) begin
                    state_d = RESP;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
`endif
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= ID_W'(N_REQ - 1);
            id_q    <= '0;
            mode_q  <= 1'b0;
            in_q    <= '0;
            res_q   <= '0;
`ifndef GRAY_CONV_FAST_EN
            idx_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            mode_q  <= mode_d;
            in_q    <= in_d;
            res_q   <= res_d;
`ifndef GRAY_CONV_FAST_EN
            idx_q   <= idx_d;
`endif
        end
    end

    // Grant strobe is combinational so the requester sees it in its grant cycle.
    assign req_ready = (!rst && state_q == IDLE && gnt_found_c) ? gnt_oh_c : '0;
    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign rsp_data  = res_q;
    assign rsp_id    = id_q;
    assign rsp_mode  = mode_q;

endmodule
